axi_gran_burst_splitter_ax_ctrl: RTL and testbench



---
 rtl/axi_gran_burst_splitter_pkg.sv | 23 ++
 rtl/axi_gran_burst_splitter_ax_ctrl_sub_len.sv | 23 ++
 rtl/axi_gran_burst_splitter_ax_ctrl.sv | 150 +++++++++++++++
 tb/tb_axi_gran_burst_splitter_ax_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_gran_burst_splitter_pkg.sv
// Shared types and the sub-burst length helper for the granular burst splitter.
package axi_gran_burst_splitter_pkg;

    typedef enum logic [1:0] {
        AX_IDLE  = 2'd0,
        AX_ALLOC = 2'd1,
        AX_ISSUE = 2'd2
    } ax_ctrl_state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Lengths are in beats-minus-one; offset never exceeds limit, so the cap cannot underflow.
    function automatic logic [7:0] sub_len(input logic [7:0] rem,
                                           input logic [7:0] limit,
                                           input logic [7:0] offset);
        logic [7:0] cap;
        cap = limit - offset;
        return (rem < cap) ? rem : cap;
    endfunction

endpackage

// File: rtl/axi_gran_burst_splitter_ax_ctrl_sub_len.sv
// Combinational sub-burst length and last-flag computation for one AX sub-burst.
module axi_gran_burst_splitter_ax_ctrl_sub_len
    import axi_gran_burst_splitter_pkg::*;
(
    input  logic [7:0] rem_i,
    input  logic [7:0] limit_i,
    input  logic [7:0] offset_i,
    input  logic       incr_i,
    output logic [7:0] len_o,
    output logic       last_o
);

    // FIXED and WRAP bursts pass through whole.
    always_comb begin
        len_o = rem_i;
        if (incr_i) begin
            len_o = sub_len(rem_i, limit_i, offset_i);
        end
    end

    assign last_o = (len_o == rem_i);

endmodule

// File: rtl/axi_gran_burst_splitter_ax_ctrl.sv
// AX channel sequencer: reserves a beat counter, then issues a burst as INCR sub-bursts.
// Optional first-sub-burst granule alignment: AXI_GRAN_BURST_SPLITTER_ALIGN_EN.
module axi_gran_burst_splitter_ax_ctrl
    import axi_gran_burst_splitter_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned IdWidth   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [7:0]           len_limit_i,
    input  logic [IdWidth-1:0]   ax_id_i,
    input  logic [AddrWidth-1:0] ax_addr_i,
    input  logic [7:0]           ax_len_i,
    input  logic [2:0]           ax_size_i,
    input  logic [1:0]           ax_burst_i,
    input  logic                 ax_valid_i,
    output logic                 ax_ready_o,
    output logic [IdWidth-1:0]   alloc_id_o,
    output logic [7:0]           alloc_len_o,
    output logic                 alloc_req_o,
    input  logic                 alloc_gnt_i,
    output logic [IdWidth-1:0]   sub_id_o,
    output logic [AddrWidth-1:0] sub_addr_o,
    output logic [7:0]           sub_len_o,
    output logic [2:0]           sub_size_o,
    output logic [1:0]           sub_burst_o,
    output logic                 sub_last_o,
    output logic                 sub_valid_o,
    input  logic                 sub_ready_i,
    output logic                 busy_o,
    output logic [1:0]           state_o
);

    typedef logic [IdWidth-1:0]   id_t;
    typedef logic [AddrWidth-1:0] addr_t;

    ax_ctrl_state_e state_q;
    id_t            id_q;
    addr_t          addr_q, addr_d;
    logic [7:0]     len_q, limit_q, rem_q, rem_d;
    logic [2:0]     size_q;
    logic [1:0]     burst_q;
    logic           ax_ready_q, alloc_req_q, sub_valid_q;

    logic [7:0]     offset;
    logic [7:0]     cur_len;
    logic           cur_last;
    logic [8:0]     beats;

`ifdef AXI_GRAN_BURST_SPLITTER_ALIGN_EN
    // Beat index within the granule; only nonzero before the first aligned boundary.
    assign offset = 8'(addr_q >> size_q) & limit_q;
`else
    assign offset = 8'd0;
`endif

    axi_gran_burst_splitter_ax_ctrl_sub_len u_sub_len (
        .rem_i    (rem_q),
        .limit_i  (limit_q),
        .offset_i (offset),
        .incr_i   (burst_q == BURST_INCR),
        .len_o    (cur_len),
        .last_o   (cur_last)
    );

    assign beats  = {1'b0, cur_len} + 9'd1;
    assign rem_d  = rem_q - cur_len - 8'd1;
    assign addr_d = addr_q + (addr_t'(beats) << size_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= AX_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            limit_q     <= '0;
            rem_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            ax_ready_q  <= 1'b0;
            alloc_req_q <= 1'b0;
            sub_valid_q <= 1'b0;
        end else begin
            case (state_q)
                AX_IDLE: begin
                    if (ax_ready_q && ax_valid_i) begin
                        id_q        <= ax_id_i;
                        addr_q      <= ax_addr_i;
                        len_q       <= ax_len_i;
                        size_q      <= ax_size_i;
                        burst_q     <= ax_burst_i;
                        limit_q     <= len_limit_i;
                        rem_q       <= ax_len_i;
                        ax_ready_q  <= 1'b0;
                        alloc_req_q <= 1'b1;
                        state_q     <= AX_ALLOC;
                    end else begin
                        ax_ready_q  <= 1'b1;
                    end
                end
                AX_ALLOC: begin
                    if (alloc_gnt_i) begin
                        alloc_req_q <= 1'b0;
                        sub_valid_q <= 1'b1;
                        state_q     <= AX_ISSUE;
                    end
                end
                AX_ISSUE: begin
                    if (sub_ready_i) begin
                        if (cur_last) begin
                            sub_valid_q <= 1'b0;
                            ax_ready_q  <= 1'b1;
                            state_q     <= AX_IDLE;
                        end else begin
                            rem_q       <= rem_d;
                            addr_q      <= addr_d;
                        end
                    end
                end
                default: begin
                    ax_ready_q  <= 1'b0;
                    alloc_req_q <= 1'b0;
                    sub_valid_q <= 1'b0;
                    state_q     <= AX_IDLE;
                end
            endcase
        end
    end

`ifdef AXI_GRAN_BURST_SPLITTER_ALIGN_EN
    granule_pow2_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q != AX_IDLE) |-> ((limit_q & (limit_q + 8'd1)) == 8'd0));
`endif

    assign ax_ready_o  = ax_ready_q;
    assign alloc_req_o = alloc_req_q;
    assign alloc_id_o  = id_q;
    assign alloc_len_o = len_q;
    assign sub_valid_o = sub_valid_q;
    assign sub_id_o    = id_q;
    assign sub_addr_o  = addr_q;
    assign sub_len_o   = cur_len;
    assign sub_size_o  = size_q;
    assign sub_burst_o = burst_q;
    assign sub_last_o  = sub_valid_q & cur_last;
    assign busy_o      = (state_q != AX_IDLE);
    assign state_o     = state_q;

endmodule

// File: tb/tb_axi_gran_burst_splitter_ax_ctrl.sv
// Scoreboard bench for the AX sequencer: beat-level reference model, randomized bursts and handshakes.
module tb_axi_gran_burst_splitter_ax_ctrl;
  import axi_gran_burst_splitter_pkg::*;

  localparam int AW = 32;
  localparam int IW = 4;
  localparam int SW = IW + AW + 8 + 3 + 2 + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    len_limit_i = '0;
  logic [IW-1:0] ax_id_i = '0;
  logic [AW-1:0] ax_addr_i = '0;
  logic [7:0]    ax_len_i = '0;
  logic [2:0]    ax_size_i = '0;
  logic [1:0]    ax_burst_i = '0;
  logic          ax_valid_i = 1'b0;
  logic          ax_ready_o;
  logic [IW-1:0] alloc_id_o;
  logic [7:0]    alloc_len_o;
  logic          alloc_req_o;
  logic          alloc_gnt_i = 1'b0;
  logic [IW-1:0] sub_id_o;
  logic [AW-1:0] sub_addr_o;
  logic [7:0]    sub_len_o;
  logic [2:0]    sub_size_o;
  logic [1:0]    sub_burst_o;
  logic          sub_last_o;
  logic          sub_valid_o;
  logic          sub_ready_i = 1'b0;
  logic          busy_o;
  logic [1:0]    state_o;

  axi_gran_burst_splitter_ax_ctrl #(.AddrWidth(AW), .IdWidth(IW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .len_limit_i(len_limit_i),
    .ax_id_i(ax_id_i), .ax_addr_i(ax_addr_i), .ax_len_i(ax_len_i),
    .ax_size_i(ax_size_i), .ax_burst_i(ax_burst_i),
    .ax_valid_i(ax_valid_i), .ax_ready_o(ax_ready_o),
    .alloc_id_o(alloc_id_o), .alloc_len_o(alloc_len_o),
    .alloc_req_o(alloc_req_o), .alloc_gnt_i(alloc_gnt_i),
    .sub_id_o(sub_id_o), .sub_addr_o(sub_addr_o), .sub_len_o(sub_len_o),
    .sub_size_o(sub_size_o), .sub_burst_o(sub_burst_o), .sub_last_o(sub_last_o),
    .sub_valid_o(sub_valid_o), .sub_ready_i(sub_ready_i),
    .busy_o(busy_o), .state_o(state_o)
  );

  // scoreboard state
  int checks = 0;
  int failures = 0;
  logic [SW-1:0]   exp_q[$];
  logic [IW+7:0]   exp_alloc_q[$];
  int sub_hs_cnt = 0;
  int busy_cycles = 0;
  bit rdy_rand = 0;
  bit gnt_rand = 0;
  bit gnt_block = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: walk the burst in beats, cutting chunks of at most limit+1 beats.
  task automatic model_push(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [7:0] limit);
    int left;
    int chunk;
    logic [AW-1:0] a;
    exp_alloc_q.push_back({id, len});
    if (burst != BURST_INCR) begin
      exp_q.push_back({id, addr, len, size, burst, 1'b1});
      return;
    end
    left = int'(len) + 1;
    a = addr;
    chunk = int'(limit) + 1;
`ifdef AXI_GRAN_BURST_SPLITTER_ALIGN_EN
    chunk = chunk - int'((a >> size) % (AW'(limit) + 1));
`endif
    while (left > 0) begin
      if (chunk > left) chunk = left;
      exp_q.push_back({id, a, 8'(chunk - 1), size, burst, (chunk == left)});
      a = a + (32'(chunk) << size);
      left = left - chunk;
      chunk = int'(limit) + 1;
    end
  endtask

  // handshake responders, driven just after the active edge
  always @(posedge clk) begin
    #1;
    sub_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    alloc_gnt_i = gnt_block ? 1'b0 : (gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // monitor: samples on the falling edge
  logic [SW-1:0] held;
  logic [SW-1:0] act;
  bit stalled = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (busy_o) busy_cycles++;
      act = {sub_id_o, sub_addr_o, sub_len_o, sub_size_o, sub_burst_o, sub_last_o};
      if (stalled && !sub_valid_o) check("sub_valid_held", 64'(sub_valid_o), 64'd1);
      if (sub_valid_o) begin
        if (stalled) check("sub_stable", 64'(act), 64'(held));
        held = act;
        stalled = !sub_ready_i;
        if (sub_ready_i) begin
          sub_hs_cnt++;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL sub_unexpected actual=0x%0h required=none", act);
          end else begin
            check("sub_payload", 64'(act), 64'(exp_q.pop_front()));
          end
        end
      end else begin
        stalled = 0;
      end
      if (alloc_req_o && alloc_gnt_i) begin
        if (exp_alloc_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL alloc_unexpected actual=0x%0h required=none", {alloc_id_o, alloc_len_o});
        end else begin
          check("alloc_payload", 64'({alloc_id_o, alloc_len_o}), 64'(exp_alloc_q.pop_front()));
        end
      end
    end
  end

  // driver: present one burst, wait for acceptance, then scramble the inputs
  task automatic send(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input logic [7:0] limit);
    int n = 0;
    @(posedge clk); #1;
    ax_valid_i = 1'b1; ax_id_i = id; ax_addr_i = addr; ax_len_i = len;
    ax_size_i = size; ax_burst_i = burst; len_limit_i = limit;
    do begin @(negedge clk); n++; end while (!ax_ready_o && n < 500);
    if (!ax_ready_o) begin
      checks++; failures++;
      $display("FAIL ax_accept_timeout actual=0 required=1");
    end else begin
      model_push(id, addr, len, size, burst, limit);
    end
    @(posedge clk); #1;
    ax_valid_i = 1'b0;
    ax_addr_i = $urandom; ax_len_i = 8'($urandom); len_limit_i = 8'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_alloc_q.size() != 0 || busy_o) && n < 8000) begin
      @(negedge clk); #1; n++;
    end
    check("drain", 64'({exp_q.size() != 0, exp_alloc_q.size() != 0, busy_o}), 64'd0);
  endtask

  function automatic logic [7:0] rand_limit();
`ifdef AXI_GRAN_BURST_SPLITTER_ALIGN_EN
    return 8'((1 << $urandom_range(0, 8)) - 1);
`else
    case ($urandom_range(0, 3))
      0: return 8'd0;
      1: return 8'd3;
      2: return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
`endif
  endfunction

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int base;
    int n;
    #3;
    check("rst_ctrl", 64'({ax_ready_o, alloc_req_o, sub_valid_o, sub_last_o, busy_o}), 64'd0);
    check("rst_sub_payload", 64'({sub_id_o, sub_addr_o, sub_len_o, sub_size_o, sub_burst_o}), 64'd0);
    check("rst_alloc_payload", 64'({alloc_id_o, alloc_len_o}), 64'd0);
    #19; rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    check("idle_ready", 64'({ax_ready_o, busy_o}), 64'b10);

    // INCR split with every handshake immediate: ALLOC + 3 ISSUE cycles busy
    busy_cycles = 0;
    send(4'h1, 32'h1000, 8'd9, 3'd3, BURST_INCR, 8'd3);
    wait_drain();
    check("occupancy_incr", 64'(busy_cycles), 64'd4);

    // WRAP passes through unsplit
    send(4'h2, 32'h2004, 8'd7, 3'd2, BURST_WRAP, 8'd1);
    wait_drain();
    send(4'h6, 32'h2100, 8'd5, 3'd1, BURST_FIXED, 8'd0);
    wait_drain();

`ifdef AXI_GRAN_BURST_SPLITTER_ALIGN_EN
    send(4'h5, 32'h1008, 8'd7, 3'd3, BURST_INCR, 8'd3);
    wait_drain();
`endif

    // grant withheld: reservation must hold steady and nothing issues
    gnt_block = 1;
    send(4'h7, 32'h5000, 8'd4, 3'd2, BURST_INCR, 8'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("gnt_hold", 64'({alloc_req_o, alloc_id_o, alloc_len_o, sub_valid_o, ax_ready_o}),
            64'({1'b1, 4'h7, 8'd4, 1'b0, 1'b0}));
    end
    gnt_block = 0;
    wait_drain();

    // one-beat sub-bursts under random backpressure
    rdy_rand = 1;
    base = sub_hs_cnt;
    send(4'h3, 32'h3000, 8'd15, 3'd1, BURST_INCR, 8'd0);
    wait_drain();
    check("limit0_count", 64'(sub_hs_cnt - base), 64'd16);
    rdy_rand = 0;

    // reset while the second sub-burst is on the bus
    base = sub_hs_cnt;
    send(4'h4, 32'h4000, 8'd9, 3'd3, BURST_INCR, 8'd3);
    n = 0;
    while (sub_hs_cnt != base + 1 && n < 100) begin @(negedge clk); #2; n++; end
    check("rst_mid_reach", 64'(sub_hs_cnt - base), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", 64'({ax_ready_o, alloc_req_o, sub_valid_o, sub_last_o, busy_o}), 64'd0);
    check("rst_mid_payload", 64'({sub_id_o, sub_addr_o, sub_len_o}), 64'd0);
    exp_q.delete();
    exp_alloc_q.delete();
    repeat (2) @(negedge clk);
    #2; rst_n = 1'b1;
    send(4'h8, 32'h6000, 8'd2, 3'd0, BURST_INCR, 8'd0);
    wait_drain();

    // randomized traffic
    rdy_rand = 1;
    gnt_rand = 1;
    repeat (40) begin
      logic [1:0] b;
      b = 2'($urandom_range(0, 2));
      send(4'($urandom), $urandom, 8'($urandom_range(0, 40)), 3'($urandom_range(0, 3)), b, rand_limit());
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
